// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - shared state type, default 1-Wire reset timing and counter sizing
package ow_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RST_LOW = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } ow_rst_state_t;

   localparam int unsigned OW_TRSTL_STD_US = 480;
   localparam int unsigned OW_TMSP_STD_US  = 70;
   localparam int unsigned OW_TRSTH_STD_US = 480;
   localparam int unsigned OW_TRSTL_OD_US  = 70;
   localparam int unsigned OW_TMSP_OD_US   = 8;
   localparam int unsigned OW_TRSTH_OD_US  = 48;

   // Bits needed to hold the longer of the low and recovery phases, in cycles.
   function automatic int ow_cnt_w(input int unsigned trstl_cyc, input int unsigned trsth_cyc);
      int unsigned m;
      m = (trstl_cyc > trsth_cyc) ? trstl_cyc : trsth_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ow_reset_presence.sv
// rtl/ow_reset_presence.sv - 1-Wire reset pulse and presence sampler, std/overdrive timing
// Optional bus-short detection output under OW_SHORT_DETECT_EN.
module ow_reset_presence
   import ow_pkg::*;
#(
   parameter int unsigned CLK_PER_US   = 1,
   parameter int unsigned TRSTL_STD_US = OW_TRSTL_STD_US,
   parameter int unsigned TMSP_STD_US  = OW_TMSP_STD_US,
   parameter int unsigned TRSTH_STD_US = OW_TRSTH_STD_US,
   parameter int unsigned TRSTL_OD_US  = OW_TRSTL_OD_US,
   parameter int unsigned TMSP_OD_US   = OW_TMSP_OD_US,
   parameter int unsigned TRSTH_OD_US  = OW_TRSTH_OD_US
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic od_mode,
   input  logic bus_in,
   output logic pull_low,
   output logic busy,
   output logic done,
   output logic presence
`ifdef OW_SHORT_DETECT_EN
   ,
   output logic bus_short
`endif
);

   localparam int unsigned STD_RSTL = TRSTL_STD_US * CLK_PER_US;
   localparam int unsigned STD_MSP  = TMSP_STD_US * CLK_PER_US;
   localparam int unsigned STD_RSTH = TRSTH_STD_US * CLK_PER_US;
   localparam int unsigned OD_RSTL  = TRSTL_OD_US * CLK_PER_US;
   localparam int unsigned OD_MSP   = TMSP_OD_US * CLK_PER_US;
   localparam int unsigned OD_RSTH  = TRSTH_OD_US * CLK_PER_US;
   localparam int unsigned MAX_RSTL = (STD_RSTL > OD_RSTL) ? STD_RSTL : OD_RSTL;
   localparam int unsigned MAX_RSTH = (STD_RSTH > OD_RSTH) ? STD_RSTH : OD_RSTH;
   localparam int CNT_W = ow_cnt_w(MAX_RSTL, MAX_RSTH);

   // Every phase needs at least one cycle and the sample point must fall inside recovery.
   if (STD_RSTL == 0 || STD_MSP == 0 || STD_RSTH == 0 ||
       OD_RSTL == 0 || OD_MSP == 0 || OD_RSTH == 0 ||
       STD_MSP > STD_RSTH || OD_MSP > OD_RSTH ||
       (MAX_RSTL >> CNT_W) != 0 || (MAX_RSTH >> CNT_W) != 0) begin : g_bad_timing
      $error("ow_reset_presence: timing limits invalid for CNT_W");
   end

   ow_rst_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             od_q, od_d;
   logic             pres_q, pres_d;
   logic [CNT_W-1:0] lim_rstl, lim_msp, lim_rsth;
`ifdef OW_SHORT_DETECT_EN
   logic             short_q, short_d;
`endif

   assign lim_rstl = od_q ? CNT_W'(OD_RSTL - 1) : CNT_W'(STD_RSTL - 1);
   assign lim_msp  = od_q ? CNT_W'(OD_MSP - 1)  : CNT_W'(STD_MSP - 1);
   assign lim_rsth = od_q ? CNT_W'(OD_RSTH - 1) : CNT_W'(STD_RSTH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         od_q    <= 1'b0;
         pres_q  <= 1'b0;
`ifdef OW_SHORT_DETECT_EN
         short_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         od_q    <= od_d;
         pres_q  <= pres_d;
`ifdef OW_SHORT_DETECT_EN
         short_q <= short_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      od_d     = od_q;
      pres_d   = pres_q;
`ifdef OW_SHORT_DETECT_EN
      short_d  = short_q;
`endif
      pull_low = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               od_d    = od_mode;
               pres_d  = 1'b0;
`ifdef OW_SHORT_DETECT_EN
               short_d = 1'b0;
`endif
               cnt_d   = '0;
               state_d = RST_LOW;
            end
         end
         RST_LOW: begin
            pull_low = 1'b1;
            busy     = 1'b1;
            if (cnt_q == lim_rstl) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            busy = 1'b1;
            if (cnt_q == lim_msp) begin
               pres_d = ~bus_in;
            end
            if (cnt_q == lim_rsth) begin
               cnt_d   = '0;
               state_d = DONE;
`ifdef OW_SHORT_DETECT_EN
               short_d = ~bus_in;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef OW_SHORT_DETECT_EN
   assign bus_short = short_q;
   assign presence  = pres_q & ~short_q;
`else
   assign presence  = pres_q;
`endif

endmodule

// File: tb/tb_ow_reset_presence.sv
// tb/tb_ow_reset_presence.sv - scoreboard bench for ow_reset_presence at 1 and 2 clocks per us
module tb_ow_reset_presence;

   typedef struct {
      int start_cyc;
      int lat;
      int pl;
      int rel;
      int msp;
      bit pres;
      bit shrt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n[2]   = '{1'b0, 1'b0};
   logic start_s[2] = '{1'b0, 1'b0};
   logic od_s[2]    = '{1'b0, 1'b0};
   logic bus_s[2]   = '{1'b1, 1'b1};
   logic pl_s[2];
   logic busy_s[2];
   logic done_s[2];
   logic pres_s[2];
`ifdef OW_SHORT_DETECT_EN
   logic short_s[2];
`endif

   int cyc = 0;
   int pl_cnt[2]   = '{0, 0};
   int win_lo[2]   = '{1, 1};
   int win_hi[2]   = '{0, 0};
   int rel_base[2] = '{0, 0};
   exp_t q0[$];
   exp_t q1[$];
   int n_chk = 0;
   int n_err = 0;

   ow_reset_presence #(.CLK_PER_US(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .start(start_s[0]), .od_mode(od_s[0]), .bus_in(bus_s[0]),
      .pull_low(pl_s[0]), .busy(busy_s[0]), .done(done_s[0]), .presence(pres_s[0])
`ifdef OW_SHORT_DETECT_EN
      , .bus_short(short_s[0])
`endif
   );

   ow_reset_presence #(.CLK_PER_US(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start_s[1]), .od_mode(od_s[1]), .bus_in(bus_s[1]),
      .pull_low(pl_s[1]), .busy(busy_s[1]), .done(done_s[1]), .presence(pres_s[1])
`ifdef OW_SHORT_DETECT_EN
      , .bus_short(short_s[1])
`endif
   );

   task automatic check_eq(input string tag, input int got, input int exp_v);
      n_chk++;
      if (got != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
      end
   endtask

   function automatic int q_size(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t q_front(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: drives the slave model on the falling edge and scores DUT outputs there.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            int   rel;
            exp_t e;
            rel = cyc - rel_base[d];
            bus_s[d] = !(rel >= win_lo[d] && rel <= win_hi[d]);
            if (q_size(d) > 0) begin
               e = q_front(d);
               if (cyc == e.start_cyc) pl_cnt[d] = 0;
               if (cyc == e.rel + e.msp - 1) begin
                  check_eq($sformatf("pres_before_sample%0d", d), int'(pres_s[d]), 0);
                  check_eq($sformatf("busy_in_release%0d", d), int'(busy_s[d]), 1);
               end
               if (cyc == e.rel + e.msp)
                  check_eq($sformatf("pres_after_sample%0d", d), int'(pres_s[d]), int'(e.pres));
            end
            if (pl_s[d]) pl_cnt[d]++;
            if (done_s[d]) begin
               if (q_size(d) == 0) begin
                  check_eq($sformatf("unexpected_done%0d", d), 1, 0);
               end else begin
                  e = q_front(d);
                  if (d == 0) void'(q0.pop_front());
                  else        void'(q1.pop_front());
                  check_eq($sformatf("done_latency%0d", d), cyc - e.start_cyc, e.lat);
                  check_eq($sformatf("pull_low_cycles%0d", d), pl_cnt[d], e.pl);
                  check_eq($sformatf("presence_at_done%0d", d), int'(pres_s[d]), int'(e.pres));
                  check_eq($sformatf("busy_at_done%0d", d), int'(busy_s[d]), 0);
                  check_eq($sformatf("pull_low_at_done%0d", d), int'(pl_s[d]), 0);
`ifdef OW_SHORT_DETECT_EN
                  check_eq($sformatf("bus_short_at_done%0d", d), int'(short_s[d]), int'(e.shrt));
`endif
               end
            end
         end
      end
   end

   // Presents start for one cycle and queues the expected outcome; the slave pulls low
   // for release-relative counter values lo..hi.
   task automatic launch(input int d, input bit od, input int lo, input int hi);
      exp_t e;
      int cpu, rstl, msp, rsth;
      cpu  = (d == 0) ? 1 : 2;
      rstl = (od ? 70 : 480) * cpu;
      msp  = (od ? 8 : 70) * cpu;
      rsth = (od ? 48 : 480) * cpu;
      e.start_cyc = cyc + 1;
      e.lat  = rstl + rsth + 1;
      e.pl   = rstl;
      e.rel  = e.start_cyc + 1 + rstl;
      e.msp  = msp;
      e.pres = (lo <= msp - 1) && (hi >= msp - 1);
      e.shrt = (lo <= rsth - 1) && (hi >= rsth - 1);
`ifdef OW_SHORT_DETECT_EN
      if (e.shrt) e.pres = 1'b0;
`endif
      win_lo[d]   = lo;
      win_hi[d]   = hi;
      rel_base[d] = e.rel;
      od_s[d]     = od;
      start_s[d]  = 1'b1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      wait_cyc(1);
      start_s[d] = 1'b0;
      od_s[d]    = ~od;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (q_size(d) > 0 && n < 5000) begin
         wait_cyc(1);
         n++;
      end
      if (q_size(d) > 0) begin
         check_eq($sformatf("done_timeout%0d", d), 0, 1);
         if (d == 0) q0.delete();
         else        q1.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cyc(3);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("reset_pull_low%0d", d), int'(pl_s[d]), 0);
         check_eq($sformatf("reset_busy%0d", d), int'(busy_s[d]), 0);
         check_eq($sformatf("reset_done%0d", d), int'(done_s[d]), 0);
         check_eq($sformatf("reset_presence%0d", d), int'(pres_s[d]), 0);
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      wait_cyc(2);

      launch(0, 1'b0, 1, 0);      wait_idle(0);
      launch(0, 1'b0, 30, 150);   wait_idle(0);
      wait_cyc(20);
      check_eq("presence_held", int'(pres_s[0]), 1);
      launch(0, 1'b0, 30, 68);    wait_idle(0);
      launch(0, 1'b0, 69, 69);    wait_idle(0);
      launch(0, 1'b0, 70, 300);   wait_idle(0);
      launch(0, 1'b1, 0, 7);      wait_idle(0);

      launch(1, 1'b1, 10, 20);    wait_idle(1);
      launch(1, 1'b1, 16, 40);    wait_idle(1);
      launch(1, 1'b0, 100, 200);  wait_idle(1);

      // Starts during RST_LOW and during DONE are dropped; the one after DONE is taken.
      launch(0, 1'b0, 1, 0);
      wait_cyc(99);
      start_s[0] = 1'b1;
      wait_cyc(1);
      start_s[0] = 1'b0;
      wait_cyc(860);
      start_s[0] = 1'b1;
      wait_cyc(1);
      launch(0, 1'b0, 60, 80);    wait_idle(0);

      launch(0, 1'b0, 69, 69);    wait_idle(0);
      launch(0, 1'b0, 1, 0);
      wait_cyc(199);
      #2 rst_n[0] = 1'b0;
      #1;
      check_eq("rst_mid_pull_low", int'(pl_s[0]), 0);
      check_eq("rst_mid_busy", int'(busy_s[0]), 0);
      check_eq("rst_mid_done", int'(done_s[0]), 0);
      check_eq("rst_mid_presence", int'(pres_s[0]), 0);
      q0.delete();
      wait_cyc(2);
      rst_n[0] = 1'b1;
      wait_cyc(1);
      launch(0, 1'b0, 1, 0);      wait_idle(0);

`ifdef OW_SHORT_DETECT_EN
      launch(0, 1'b0, 0, 479);    wait_idle(0);
      launch(0, 1'b0, 1, 0);
      check_eq("bus_short_cleared", int'(short_s[0]), 0);
      wait_idle(0);
`endif

      wait_cyc(5);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ow_reset_presence.md
Name: ow_reset_presence

Overview:
- Parametrised successor to the one-wire reset sender. The master issues a 1-Wire reset pulse, releases the bus, samples the slave presence pulse, then waits out the recovery time.
- Supports standard and overdrive timing, selected per transaction, with timing derived from clock frequency.
- Sits between the one-wire transaction sequencer (start/done handshake) and the open-drain bus pad (pull_low out, bus_in in).

Parameters:
- CLK_PER_US, 1, clock cycles per microsecond; all timing is scaled by it.
- TRSTL_STD_US, 480, standard reset-low time.
- TMSP_STD_US, 70, standard presence sample point, measured from release.
- TRSTH_STD_US, 480, standard release/recovery time.
- TRSTL_OD_US, 70, overdrive reset-low time.
- TMSP_OD_US, 8, overdrive presence sample point.
- TRSTH_OD_US, 48, overdrive recovery time.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a reset sequence; honoured only in IDLE.
- od_mode  in  1  1 = overdrive timing; sampled in the cycle start is accepted.
- bus_in  in  1  sensed bus level, already synchronised by the pad wrapper.
- pull_low  out  1  1 = drive the bus low.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of the sequence.
- presence  out  1  1 = slave presence detected; held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, counter=0, pull_low=0, busy=0, done=0, presence=0.
  - Reset mid-sequence releases the bus immediately, with no done pulse.
- Counter width CNT_W = $clog2(max(TRSTL,TRSTH)*CLK_PER_US+1).
  - Limits are computed as products of parameters.
  - Limits are not allowed to exceed CNT_W; an elaboration check enforces this.
- States: IDLE -> RST_LOW -> RELEASE -> DONE -> IDLE.
- IDLE:
  - pull_low=0.
  - When start=1: latch od_mode, clear presence and counter, go to RST_LOW.
- RST_LOW:
  - pull_low=1, busy=1.
  - Stays exactly TRSTL*CLK_PER_US cycles, counting 0..N-1.
  - Then counter=0 and go to RELEASE.
- RELEASE:
  - pull_low=0.
  - On the cycle where counter == TMSP*CLK_PER_US-1, register presence <= ~bus_in. This is the only sample.
  - Leave when counter == TRSTH*CLK_PER_US-1.
- DONE:
  - Lasts one cycle: done=1, busy drops to 0 in this same cycle, then return to IDLE.
- start asserted while not in IDLE is ignored; it is not queued.
- start in the same cycle as DONE is ignored; the earliest acceptance is the following cycle.
- od_mode changes during a sequence have no effect.
- Standard timing at CLK_PER_US=1:
  - pull_low high for 480 cycles, starting the cycle after start.
  - done occurs 480+480+1 cycles after the start edge.
- presence reflects only the sample point. Low pulses outside the sample point are ignored.

Optional Feature:
- Macro OW_SHORT_DETECT_EN.
- With it defined:
  - Adds output bus_short (1 bit, reset 0).
  - On the last RELEASE cycle, if bus_in==0, bus_short=1. The bus is still low after recovery, which indicates a short or a stuck slave.
  - bus_short is cleared on the next accepted start.
  - presence is forced to 0 whenever bus_short is set.
- Without it: no port, no logic, and presence is as described above.

Decomposition:
- Shared package ow_pkg holds:
  - State enum ow_rst_state_t (IDLE, RST_LOW, RELEASE, DONE).
  - Default timing constants in microseconds for standard and overdrive.
  - The shared CNT_W helper function.
- No sub-module. A single FSM plus counter; the timing mux by latched od_mode is inline.

Test Plan:
- CLK_PER_US=1, od_mode=0, bus_in held 1, start pulse:
  - pull_low=1 for exactly 480 cycles.
  - done pulse 961 cycles after start.
  - presence=0.
- Standard mode, slave model drives bus_in=0 from 30 to 150 cycles after release:
  - presence=1, latched at release+69.
  - It stays 1 after done until the next start.
- CLK_PER_US=2, od_mode=1:
  - pull_low high for 140 cycles.
  - Sample at release+15.
  - done at 140+96+1 cycles.
- start re-pulsed at cycle 100 and at the DONE cycle: both ignored, sequence timing unchanged. start on the cycle after DONE is accepted.
- rst_n=0 asserted at cycle 200 of RST_LOW:
  - pull_low=0 asynchronously, no done pulse.
  - All outputs are 0; a new start after reset gives full 480-cycle timing.
- OW_SHORT_DETECT_EN defined, bus_in held 0 throughout release:
  - bus_short=1, presence=0 at done.
  - Next start clears bus_short.
